// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the data memory (slave).
// The LSU issues registered req/addr/sel/wdata; the memory answers with a one-cycle ack carrying rdata.
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  dbus_req;
  logic                  dbus_we;
  logic [ADDR_W-1:0]     dbus_addr;
  logic [DATA_W/8-1:0]   dbus_sel;
  logic [DATA_W-1:0]     dbus_wdata;
  logic [DATA_W-1:0]     dbus_rdata;
  logic                  dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs a req/ack data-bus access for EX/MEM memory ops,
// stalls the pipeline while it is in flight and hands aligned, extended results to MEM/WB.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        stall,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [7:0]        mem_aluop,
  input  logic [ADDR_W-1:0] mem_mem_addr,
  input  logic [DATA_W-1:0] mem_reg2,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              stallreq_mem,
  output logic              addr_err,
  mem_lsu_if.master         dbus
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  logic              is_byte, is_half, is_word, is_load, is_store;
  logic              misaligned, mem_go;
  logic [3:0]        sel_d;
  logic [DATA_W-1:0] wdata_d;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] load_data;
  logic              unused_stall_bits;

  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  assign is_byte  = mem_aluop inside {OP_LB, OP_LBU, OP_SB};
  assign is_half  = mem_aluop inside {OP_LH, OP_LHU, OP_SH};
  assign is_word  = mem_aluop inside {OP_LW, OP_SW};
  assign is_load  = mem_aluop inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_store = mem_aluop inside {OP_SB, OP_SH, OP_SW};

  assign misaligned = (is_half & mem_mem_addr[0]) | (is_word & (mem_mem_addr[1:0] != 2'b00));
  assign mem_go     = (is_load | is_store) & ~misaligned;
  assign addr_err   = misaligned;

  // Big-endian lane enables and store-data replication for the request about to be issued.
  always_comb begin
    sel_d   = 4'b0000;
    wdata_d = mem_reg2;
    if (is_byte) begin
      wdata_d = {4{mem_reg2[7:0]}};
      case (mem_mem_addr[1:0])
        2'd0:    sel_d = 4'b1000;
        2'd1:    sel_d = 4'b0100;
        2'd2:    sel_d = 4'b0010;
        default: sel_d = 4'b0001;
      endcase
    end else if (is_half) begin
      wdata_d = {2{mem_reg2[15:0]}};
      sel_d   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
    end else if (is_word) begin
      sel_d = 4'b1111;
    end
  end

  // Pick the addressed lane(s) out of the captured read word and extend them.
  always_comb begin
    case (mem_mem_addr[1:0])
      2'd0:    lane_byte = rdata_q[31:24];
      2'd1:    lane_byte = rdata_q[23:16];
      2'd2:    lane_byte = rdata_q[15:8];
      default: lane_byte = rdata_q[7:0];
    endcase
    lane_half = mem_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (mem_aluop)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'h0, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'h0, lane_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    stallreq_mem = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    unique case (state_q)
      IDLE: begin
        if (misaligned) begin
          wb_wreg = 1'b0;
        end else if (mem_go) begin
          stallreq_mem = 1'b1;
          wb_wreg      = 1'b0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        stallreq_mem = 1'b1;
        wb_wreg      = 1'b0;
        if (dbus.dbus_ack) state_d = DONE;
      end
      DONE: begin
        if (is_load) wb_wdata = load_data;
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered: loaded on leaving IDLE, dropped on the ack edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      rdata_q         <= '0;
      dbus.dbus_req   <= 1'b0;
      dbus.dbus_we    <= 1'b0;
      dbus.dbus_addr  <= '0;
      dbus.dbus_sel   <= '0;
      dbus.dbus_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_go) begin
        dbus.dbus_req   <= 1'b1;
        dbus.dbus_we    <= is_store;
        dbus.dbus_addr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
        dbus.dbus_sel   <= sel_d;
        dbus.dbus_wdata <= wdata_d;
      end else if (state_q == BUSY && dbus.dbus_ack) begin
        rdata_q       <= dbus.dbus_rdata;
        dbus.dbus_req <= 1'b0;
        dbus.dbus_we  <= 1'b0;
        dbus.dbus_sel <= '0;
      end
    end
  end

endmodule
